pipo_share_arb: RTL
===================

# pipo_share_arb

Arbitrated write-port controller for a shared W-bit parallel-in/parallel-out register. Two requesters present level requests with parallel data. The block grants one at a time, loads the winner's data into the owned register and enforces a minimum hold window before the next grant. It sits between producer logic and any consumer that reads the PIPO contents.

## Interface
- `W`, default 4: register / data width.
- `HOLD_CYCLES`, default 2: hold cycles after each load before re-arbitration; legal 0..15.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  requester 0 level request.
- `req1`  in  1  requester 1 level request.
- `din0`  in  W  requester 0 parallel data.
- `din1`  in  W  requester 1 parallel data.
- `out`  out  W  shared register contents.
- `gnt0`  out  1  one-cycle grant to requester 0; `out` holds `din0` from this cycle.
- `gnt1`  out  1  one-cycle grant to requester 1.
- `upd`  out  1  one-cycle pulse; `out` changed on this edge.
- `busy`  out  1  high when state is not IDLE.

## Operation
- Reset (`rst`=1 at a rising edge) sets:
  - state IDLE, `out`=0, `gnt0`=`gnt1`=`upd`=`busy`=0;
  - hold counter 0, last-winner pointer = 1, so requester 0 wins the first tie.
- FSM states are IDLE, GRANT and HOLD. All outputs are registered.
- IDLE:
  - If no request is sampled, stay in IDLE.
  - If exactly one request is sampled, that requester wins.
  - If both are sampled, the tie-break rule selects the winner (see Configuration).
  - On the next edge: go to GRANT, `out` <= winner's din (sampled in the IDLE cycle), winner's gnt=1, `upd`=1, `busy`=1.
- GRANT lasts one cycle; gnt and `upd` deassert on the next edge.
  - If `HOLD_CYCLES`=0, go to IDLE.
  - Otherwise go to HOLD and load the counter with `HOLD_CYCLES`-1.
- HOLD:
  - Decrement the counter each cycle. Move to IDLE on the edge where the counter is 0.
  - `out` is frozen; requests are ignored (not queued).
- Requests are level-sensitive, not latched. A requester deasserts `req` after seeing its gnt. A request still high when the FSM returns to IDLE competes again.
- The pointer updates to the winner's index on entry to GRANT.
- `din` changes outside the IDLE sample cycle have no effect.
- Reset mid-GRANT or mid-HOLD aborts the window. The next cycle is IDLE with `out`=0, and the pointer returns to 1.

## Timing
- Request-to-grant latency: one edge.
  - A req sampled high in an IDLE cycle T gives gnt/`upd`/new `out` visible in cycle T+1.
- Minimum spacing between consecutive grants is `HOLD_CYCLES`+2 cycles: GRANT, H×HOLD, IDLE.
- `busy` is high for `HOLD_CYCLES`+1 cycles per grant.
- `gnt0` and `gnt1` are never both high. At most one `upd` pulse per grant.
- A request asserted during GRANT or HOLD is served no earlier than the cycle after the FSM re-enters IDLE.

## Configuration
- `PIPO_ARB_RR_EN` defined:
  - Round-robin on ties. The winner is the requester that is not the last winner.
  - With both requests held continuously, grants alternate 0,1,0,1…
- `PIPO_ARB_RR_EN` undefined:
  - Fixed priority; requester 0 always wins ties.
  - The pointer is still maintained but ignored.
  - With both requests held continuously, requester 1 is never granted.

## Test plan
- Reset: hold `rst` for 2 cycles with both reqs high.
  - Required: `out`=0000, gnt/`upd`/`busy`=0 throughout.
  - First release cycle is IDLE; `gnt0` asserts one edge later.
- Single request, W=4, HOLD_CYCLES=2: `req0`=1 with `din0`=1010 in IDLE cycle T, dropped after gnt.
  - Required: cycle T+1 `gnt0`=1, `upd`=1, `out`=1010.
  - `busy` high for cycles T+1..T+3, low at T+4.
- Tie with RR_EN: `req0`=`req1`=1 held, `din0`=0011, `din1`=1100.
  - Required: grants 0,1,0 at 4-cycle spacing.
  - `out` sequence 0011, 1100, 0011.
- Tie without RR_EN: same stimulus.
  - Required: only `gnt0` pulses, every 4 cycles; `out` stays 0011.
- Request during HOLD: `req1` rises during HOLD of a requester-0 grant.
  - Required: no `gnt1` until the cycle after IDLE re-entry; `out` is unchanged in HOLD.
- Reset mid-HOLD, then HOLD_CYCLES=0 build:
  - Required: `rst` in HOLD clears `out` to 0000 and `busy` to 0 on that edge.
  - With `HOLD_CYCLES`=0 and `req0` held, `gnt0` pulses every 2 cycles.

Source files
------------

// File: rtl/pipo_share_arb.sv
// Two-requester arbitrated loader for a shared W-bit PIPO register with a post-load hold window.
// Define PIPO_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
`timescale 1ns/1ps
module pipo_share_arb #(
   parameter int unsigned W           = 4,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] din0,
   input  logic [W-1:0] din1,
   output logic [W-1:0] out,
   output logic         gnt0,
   output logic         gnt1,
   output logic         upd,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

   localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

   state_t       state, state_nxt;
   logic [3:0]   cnt, cnt_nxt;
   logic         ptr, ptr_nxt;
   logic [W-1:0] out_nxt;
   logic         gnt0_nxt, gnt1_nxt, upd_nxt, busy_nxt;
   logic         tie_win1, win1;

   // ptr is the last winner; in round-robin the other requester takes a tie
`ifdef PIPO_ARB_RR_EN
   assign tie_win1 = ~ptr;
`else
   assign tie_win1 = 1'b0;
`endif

   assign win1 = req1 & (~req0 | tie_win1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      out_nxt   = out;
      gnt0_nxt  = 1'b0;
      gnt1_nxt  = 1'b0;
      upd_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (req0 | req1) begin
               state_nxt = GRANT;
               ptr_nxt   = win1;
               out_nxt   = win1 ? din1 : din0;
               gnt0_nxt  = ~win1;
               gnt1_nxt  = win1;
               upd_nxt   = 1'b1;
            end
         end
         GRANT: begin
            if (HOLD_CYCLES == 0) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (cnt == 4'd0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         ptr   <= 1'b1;
         out   <= '0;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         upd   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ptr   <= ptr_nxt;
         out   <= out_nxt;
         gnt0  <= gnt0_nxt;
         gnt1  <= gnt1_nxt;
         upd   <= upd_nxt;
         busy  <= busy_nxt;
      end
   end

endmodule
